// File: rtl/dmem_if.sv
// Data-port bundle between the CPU (master) and the data-memory responder (slave).
interface dmem_if;
    logic [31:0] d_addr;
    logic        d_read;
    logic        d_write;
    logic [3:0]  d_byte_enable;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_resp;
    logic        d_err;

    modport master (
        output d_addr, d_read, d_write, d_byte_enable, d_wdata,
        input  d_rdata, d_resp, d_err
    );

    modport slave (
        input  d_addr, d_read, d_write, d_byte_enable, d_wdata,
        output d_rdata, d_resp, d_err
    );
endinterface

// File: rtl/dmem_responder.sv
// Fixed-latency data-memory responder: accepts one request while idle and answers
// with a one-cycle d_resp pulse LATENCY cycles later from an internal word array.
module dmem_responder #(
    parameter int unsigned LATENCY     = 3,
    parameter int unsigned DEPTH_WORDS = 256
) (
    input logic   clk,
    input logic   rst,
    dmem_if.slave bus
);
    localparam int unsigned CntW = $clog2(LATENCY + 1);
    localparam int unsigned IdxW = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            accept;

    logic [IdxW-1:0] idx_q;
    logic [31:0]     wdata_q;
    logic [3:0]      be_q;
    logic            rd_q;
    logic            wr_q;
    logic            fault_q;
    logic [31:0]     rdata_q;
    logic [31:0]     rd_word;
    logic            oob;
    logic            in_resp;

    logic [31:0] mem [DEPTH_WORDS];

    // Range check spans the whole word address so high address bits cannot alias.
    assign oob = {2'b00, bus.d_addr[31:2]} >= DEPTH_WORDS;

    logic unused_addr_lsb;
    assign unused_addr_lsb = ^bus.d_addr[1:0];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        case (state_q)
            StIdle: begin
                if (bus.d_read || bus.d_write) begin
                    accept  = 1'b1;
                    cnt_d   = CntW'(LATENCY - 1);
                    state_d = (LATENCY == 1) ? StResp : StWait;
                end
            end
            StWait: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CntW'(1)) begin
                    state_d = StResp;
                end
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign in_resp = (state_q == StResp);
    assign rd_word = fault_q ? 32'h0 : mem[idx_q];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            idx_q   <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            fault_q <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                idx_q   <= bus.d_addr[IdxW+1:2];
                wdata_q <= bus.d_wdata;
                be_q    <= bus.d_byte_enable;
                rd_q    <= bus.d_read;
                wr_q    <= bus.d_write & ~bus.d_read;
                fault_q <= oob | (bus.d_read & bus.d_write);
            end
            if (in_resp && rd_q) begin
                rdata_q <= rd_word;
            end
        end
    end

    // Array is never reset; a write commits only on the edge that ends the response.
    always_ff @(posedge clk) begin
        if (in_resp && wr_q && !fault_q && !rst) begin
            for (int i = 0; i < 4; i++) begin
                if (be_q[i]) begin
                    mem[idx_q][8*i +: 8] <= wdata_q[8*i +: 8];
                end
            end
        end
    end

    assign bus.d_resp  = in_resp;
    assign bus.d_err   = in_resp & fault_q;
    assign bus.d_rdata = (in_resp && rd_q) ? rd_word : rdata_q;
endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed scenarios plus randomized traffic checked
// against a word-array reference model.
module tb_dmem_responder;
    localparam int LAT   = 3;
    localparam int DEPTH = 256;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    logic [31:0] model_mem [DEPTH];
    logic [31:0] model_rdata;

    dmem_if bus ();
    dmem_if bus1 ();

    dmem_responder #(.LATENCY(LAT), .DEPTH_WORDS(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    dmem_responder #(.LATENCY(1), .DEPTH_WORDS(16)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] lane_mask(input logic [3:0] be);
        return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    endfunction

    // Drive one request in an idle cycle, hold it until d_resp, then drop it.
    task automatic xact(input logic rd, input logic wr, input logic [31:0] addr,
                        input logic [3:0] be, input logic [31:0] data, output int lat,
                        output logic [31:0] rdata, output logic err);
        lat   = -1;
        rdata = '0;
        err   = 1'b0;
        @(negedge clk);
        bus.d_read        = rd;
        bus.d_write       = wr;
        bus.d_addr        = addr;
        bus.d_byte_enable = be;
        bus.d_wdata       = data;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.d_resp === 1'b1) begin
                lat   = c;
                rdata = bus.d_rdata;
                err   = bus.d_err;
                break;
            end
        end
        bus.d_read  = 1'b0;
        bus.d_write = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++;
        if (bus.d_resp !== 1'b0 || bus.d_err !== 1'b0 || bus.d_rdata !== 32'h0) begin
            failures++;
            $display("FAIL reset_outputs: resp=%b err=%b rdata=%h, want 0/0/0",
                     bus.d_resp, bus.d_err, bus.d_rdata);
        end
        checks++;
        if (bus1.d_resp !== 1'b0 || bus1.d_err !== 1'b0 || bus1.d_rdata !== 32'h0) begin
            failures++;
            $display("FAIL reset_outputs_lat1: resp=%b err=%b rdata=%h, want 0/0/0",
                     bus1.d_resp, bus1.d_err, bus1.d_rdata);
        end
        rst = 1'b0;
        model_rdata = 32'h0;
    endtask

    task automatic test_fill();
        int lat; logic [31:0] r; logic e; logic [31:0] v;
        for (int i = 0; i < DEPTH; i++) begin
            v = $urandom;
            xact(1'b0, 1'b1, 32'(i * 4), 4'hf, v, lat, r, e);
            model_mem[i] = v;
            checks++;
            if (lat !== LAT || e !== 1'b0) begin
                failures++;
                $display("FAIL fill_write[%0d]: lat=%0d err=%b, want %0d/0", i, lat, e, LAT);
            end
        end
    endtask

    task automatic test_basic();
        int lat; logic [31:0] r; logic e;
        xact(1'b0, 1'b1, 32'h10, 4'hf, 32'hDEADBEEF, lat, r, e);
        model_mem[4] = 32'hDEADBEEF;
        checks++;
        if (lat !== LAT || e !== 1'b0 || r !== model_rdata) begin
            failures++;
            $display("FAIL basic_write: lat=%0d err=%b rdata=%h, want %0d/0/%h",
                     lat, e, r, LAT, model_rdata);
        end
        xact(1'b1, 1'b0, 32'h10, 4'h0, 32'h0, lat, r, e);
        model_rdata = 32'hDEADBEEF;
        checks++;
        if (lat !== LAT || e !== 1'b0 || r !== 32'hDEADBEEF) begin
            failures++;
            $display("FAIL basic_read: lat=%0d err=%b rdata=%h, want %0d/0/deadbeef", lat, e, r, LAT);
        end
    endtask

    task automatic test_partial_write();
        int lat; logic [31:0] r; logic e;
        xact(1'b0, 1'b1, 32'h20, 4'hf, 32'h11223344, lat, r, e);
        xact(1'b0, 1'b1, 32'h20, 4'b0010, 32'h0000AB00, lat, r, e);
        xact(1'b1, 1'b0, 32'h20, 4'h0, 32'h0, lat, r, e);
        checks++;
        if (r !== 32'h1122AB44 || e !== 1'b0) begin
            failures++;
            $display("FAIL partial_write: rdata=%h err=%b, want 1122ab44/0", r, e);
        end
        xact(1'b0, 1'b1, 32'h20, 4'b0000, 32'hFFFFFFFF, lat, r, e);
        checks++;
        if (lat !== LAT || e !== 1'b0) begin
            failures++;
            $display("FAIL be0_write_resp: lat=%0d err=%b, want %0d/0", lat, e, LAT);
        end
        xact(1'b1, 1'b0, 32'h20, 4'h0, 32'h0, lat, r, e);
        checks++;
        if (r !== 32'h1122AB44) begin
            failures++;
            $display("FAIL be0_no_change: rdata=%h, want 1122ab44", r);
        end
        model_mem[8] = 32'h1122AB44;
        model_rdata  = 32'h1122AB44;
    endtask

    task automatic test_back_to_back();
        int first; int second; int highs; logic [31:0] r0; logic [31:0] r1;
        first = -1; second = -1; highs = 0; r0 = '0; r1 = '0;
        @(negedge clk);
        bus.d_read  = 1'b1;
        bus.d_write = 1'b0;
        bus.d_addr  = 32'h0;
        for (int c = 1; c <= 14; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.d_resp === 1'b1) begin
                highs++;
                if (first < 0) begin
                    first = c; r0 = bus.d_rdata; bus.d_addr = 32'h4;
                end else if (second < 0) begin
                    second = c; r1 = bus.d_rdata; bus.d_read = 1'b0;
                end
            end
        end
        bus.d_read = 1'b0;
        model_rdata = model_mem[1];
        checks++;
        if (first !== LAT || second - first !== LAT + 1) begin
            failures++;
            $display("FAIL b2b_timing: first=%0d second=%0d, want %0d/%0d", first, second, LAT,
                     2 * LAT + 1);
        end
        checks++;
        if (highs !== 2) begin
            failures++;
            $display("FAIL b2b_pulse_count: high_cycles=%0d, want 2", highs);
        end
        checks++;
        if (r0 !== model_mem[0] || r1 !== model_mem[1]) begin
            failures++;
            $display("FAIL b2b_data: r0=%h r1=%h, want %h/%h", r0, r1, model_mem[0], model_mem[1]);
        end
    endtask

    task automatic test_faults();
        int lat; logic [31:0] r; logic e;
        xact(1'b1, 1'b0, 32'(DEPTH * 4), 4'h0, 32'h0, lat, r, e);
        checks++;
        if (lat !== LAT || e !== 1'b1 || r !== 32'h0) begin
            failures++;
            $display("FAIL oob_read: lat=%0d err=%b rdata=%h, want %0d/1/0", lat, e, r, LAT);
        end
        xact(1'b1, 1'b0, 32'h80000000, 4'h0, 32'h0, lat, r, e);
        checks++;
        if (e !== 1'b1 || r !== 32'h0) begin
            failures++;
            $display("FAIL oob_high_read: err=%b rdata=%h, want 1/0", e, r);
        end
        xact(1'b0, 1'b1, 32'(DEPTH * 4), 4'hf, ~model_mem[0], lat, r, e);
        checks++;
        if (lat !== LAT || e !== 1'b1 || r !== 32'h0) begin
            failures++;
            $display("FAIL oob_write: lat=%0d err=%b rdata=%h, want %0d/1/0", lat, e, r, LAT);
        end
        xact(1'b1, 1'b1, 32'h10, 4'hf, ~model_mem[4], lat, r, e);
        checks++;
        if (lat !== LAT || e !== 1'b1 || r !== 32'h0) begin
            failures++;
            $display("FAIL rd_wr_both: lat=%0d err=%b rdata=%h, want %0d/1/0", lat, e, r, LAT);
        end
        xact(1'b1, 1'b0, 32'h0, 4'h0, 32'h0, lat, r, e);
        checks++;
        if (r !== model_mem[0] || e !== 1'b0) begin
            failures++;
            $display("FAIL oob_write_no_alias: rdata=%h err=%b, want %h/0", r, e, model_mem[0]);
        end
        xact(1'b1, 1'b0, 32'h10, 4'h0, 32'h0, lat, r, e);
        checks++;
        if (r !== model_mem[4]) begin
            failures++;
            $display("FAIL rd_wr_both_no_write: rdata=%h, want %h", r, model_mem[4]);
        end
        model_rdata = model_mem[4];
    endtask

    task automatic test_reset_mid_write();
        int lat; logic [31:0] r; logic e; int stale;
        xact(1'b0, 1'b1, 32'h30, 4'hf, 32'hA5A50F0F, lat, r, e);
        model_mem[12] = 32'hA5A50F0F;
        xact(1'b1, 1'b0, 32'h30, 4'h0, 32'h0, lat, r, e);
        @(negedge clk);
        bus.d_write       = 1'b1;
        bus.d_addr        = 32'h30;
        bus.d_byte_enable = 4'hf;
        bus.d_wdata       = 32'h5A5AF0F0;
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (bus.d_resp !== 1'b0 || bus.d_err !== 1'b0 || bus.d_rdata !== 32'h0) begin
            failures++;
            $display("FAIL async_reset_outputs: resp=%b err=%b rdata=%h, want 0/0/0",
                     bus.d_resp, bus.d_err, bus.d_rdata);
        end
        bus.d_write = 1'b0;
        model_rdata = 32'h0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        stale = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (bus.d_resp !== 1'b0) stale++;
        end
        checks++;
        if (stale !== 0) begin
            failures++;
            $display("FAIL stale_resp: resp_cycles=%0d, want 0", stale);
        end
        xact(1'b1, 1'b0, 32'h30, 4'h0, 32'h0, lat, r, e);
        model_rdata = model_mem[12];
        checks++;
        if (lat !== LAT || r !== 32'hA5A50F0F) begin
            failures++;
            $display("FAIL write_dropped_on_reset: lat=%0d rdata=%h, want %0d/a5a50f0f", lat, r, LAT);
        end
    endtask

    task automatic test_random();
        int lat; logic [31:0] r; logic e;
        logic rd; logic wr; logic [31:0] addr; logic [3:0] be; logic [31:0] data;
        logic exp_err; logic [31:0] exp_rdata; int kind; int idx;
        for (int n = 0; n < 60; n++) begin
            kind = int'($urandom_range(0, 9));
            rd   = (kind < 5) || (kind == 9);
            wr   = (kind >= 5);
            if ($urandom_range(0, 7) == 0) addr = $urandom | 32'h00000400;
            else addr = 32'($urandom_range(0, DEPTH - 1) * 4) | 32'($urandom_range(0, 3));
            be   = 4'($urandom_range(0, 15));
            data = $urandom;
            idx  = int'(addr >> 2);
            exp_err = (rd && wr) || (addr[31:2] >= 30'(DEPTH));
            xact(rd, wr, addr, be, data, lat, r, e);
            if (rd) begin
                exp_rdata = exp_err ? 32'h0 : model_mem[idx];
                model_rdata = exp_rdata;
            end else begin
                exp_rdata = model_rdata;
                if (!exp_err) begin
                    model_mem[idx] = (model_mem[idx] & ~lane_mask(be)) | (data & lane_mask(be));
                end
            end
            checks++;
            if (lat !== LAT) begin
                failures++;
                $display("FAIL rand_lat[%0d]: lat=%0d, want %0d", n, lat, LAT);
            end
            checks++;
            if (e !== exp_err) begin
                failures++;
                $display("FAIL rand_err[%0d]: addr=%h rd=%b wr=%b err=%b, want %b",
                         n, addr, rd, wr, e, exp_err);
            end
            checks++;
            if (r !== exp_rdata) begin
                failures++;
                $display("FAIL rand_rdata[%0d]: addr=%h rd=%b wr=%b rdata=%h, want %h",
                         n, addr, rd, wr, r, exp_rdata);
            end
        end
    endtask

    task automatic test_latency1();
        int pulses;
        @(negedge clk);
        bus1.d_write       = 1'b1;
        bus1.d_read        = 1'b0;
        bus1.d_addr        = 32'h8;
        bus1.d_byte_enable = 4'hf;
        bus1.d_wdata       = 32'hC0FFEE11;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (bus1.d_resp !== 1'b1 || bus1.d_err !== 1'b0) begin
            failures++;
            $display("FAIL lat1_write_resp: resp=%b err=%b, want 1/0", bus1.d_resp, bus1.d_err);
        end
        bus1.d_write = 1'b0;
        @(negedge clk);
        bus1.d_read = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (bus1.d_resp !== 1'b1 || bus1.d_rdata !== 32'hC0FFEE11) begin
            failures++;
            $display("FAIL lat1_read: resp=%b rdata=%h, want 1/c0ffee11", bus1.d_resp, bus1.d_rdata);
        end
        bus1.d_read = 1'b0;
        pulses = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (bus1.d_resp !== 1'b0) pulses++;
        end
        checks++;
        if (pulses !== 0) begin
            failures++;
            $display("FAIL lat1_single_pulse: extra_resp_cycles=%0d, want 0", pulses);
        end
        checks++;
        if (bus1.d_rdata !== 32'hC0FFEE11) begin
            failures++;
            $display("FAIL lat1_rdata_hold: rdata=%h, want c0ffee11", bus1.d_rdata);
        end
    endtask

    initial begin
        bus.d_addr         = '0;
        bus.d_read         = 1'b0;
        bus.d_write        = 1'b0;
        bus.d_byte_enable  = '0;
        bus.d_wdata        = '0;
        bus1.d_addr        = '0;
        bus1.d_read        = 1'b0;
        bus1.d_write       = 1'b0;
        bus1.d_byte_enable = '0;
        bus1.d_wdata       = '0;
        test_reset();
        test_fill();
        test_basic();
        test_partial_write();
        test_back_to_back();
        test_faults();
        test_reset_mid_write();
        test_random();
        test_latency1();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
